// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit FND scan controller.
package fnd_pkg;

    localparam int FND_DIGITS = 4;
    localparam int BCD_MAX    = 9999;
    localparam logic [FND_DIGITS-1:0] SEL_OFF = '1;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    // Scan prescaler terminal count: system clocks per digit dwell.
    function automatic int div_calc(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, MSB first.
//
//  state     | meaning
//  ----------+------------------------------------------------------
//  CONV_IDLE | waiting for i_start; accumulator holds stale data
//  CONV_RUN  | shifting; r_cnt counts remaining shifts down to 0
//
// o_done pulses in the last RUN cycle with the finished value on o_bcd;
// o_bcd is only meaningful while o_done is high.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = FND_DIGITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t            r_state;
    conv_state_t            w_state_next;
    logic [BIN_W-1:0]       r_bin;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic [4*DIGITS-1:0]    w_add3;
    logic [4*DIGITS-1:0]    w_bcd_shift;
    logic                   w_last;

    // Add-3 correction on every nibble >= 5, then shift in the next input bit.
    always_comb begin
        w_add3 = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_add3[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_bcd_shift = {w_add3[4*DIGITS-2:0], r_bin[BIN_W-1]};
    end

    assign w_last = (r_state == CONV_RUN) && (r_cnt == '0);

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CONV_IDLE: if (i_start) w_state_next = CONV_RUN;
            CONV_RUN:  if (w_last)  w_state_next = CONV_IDLE;
            default:   w_state_next = CONV_IDLE;
        endcase
    end

    // State register plus shift/accumulate datapath.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CONV_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CONV_IDLE) begin
                if (i_start) begin
                    r_bin <= i_bin;
                    r_bcd <= '0;
                    r_cnt <= CNT_W'(BIN_W - 1);
                end
            end else begin
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_bcd <= w_bcd_shift;
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_busy = (r_state == CONV_RUN);
    assign o_done = w_last;
    assign o_bcd  = w_bcd_shift;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Binary-to-BCD front end and time-multiplexed digit scanner for the FND decoder.
// The display register is written only when a conversion finishes; the scan
// prescaler runs freely from reset and is never disturbed by loads.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int DIGITS  = FND_DIGITS,
    parameter int BIN_W   = 14
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [BIN_W-1:0]    i_bin,
    input  logic                i_lz_blank,
    output logic                o_busy,
    output logic [DIGITS-1:0]   o_digit_sel,
    output logic [3:0]          o_bcd,
    output logic                o_blank
);

    localparam int DIV   = div_calc(CLK_HZ, SCAN_HZ);
    localparam int PRE_W = $clog2(DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0]       r_pre;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_guard;
    logic [4*DIGITS-1:0]    r_disp;
    logic [DIGITS-1:0]      r_digit_sel;
    logic [3:0]             r_bcd;
    logic                   r_blank;

    logic [BIN_W-1:0]       w_bin_sat;
    logic                   w_start;
    logic                   w_conv_busy;
    logic                   w_conv_done;
    logic [4*DIGITS-1:0]    w_conv_bcd;
    logic [4*DIGITS-1:0]    w_disp_next;
    logic [3:0]             w_digit;
    logic                   w_upper_zero;
    logic                   w_blank;
    logic [DIGITS-1:0]      w_sel;

    // Clamp out-of-range inputs to the largest displayable value.
    always_comb begin
        w_bin_sat = i_bin;
        if (32'(i_bin) > 32'(BCD_MAX)) begin
            w_bin_sat = BIN_W'(BCD_MAX);
        end
    end

    assign w_start = i_load & ~w_conv_busy;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_bin   (w_bin_sat),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    // The finished value is forwarded so it reaches the pins in the same cycle busy drops.
    assign w_disp_next = w_conv_done ? w_conv_bcd : r_disp;

    // Display register: atomic update on conversion completion only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp <= '0;
        end else if (w_conv_done) begin
            r_disp <= w_conv_bcd;
        end
    end

    // Scan prescaler; each wrap advances the digit index and arms one guard cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_guard <= 1'b0;
        end else if (r_pre == PRE_W'(DIV - 1)) begin
            r_pre   <= '0;
            r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            r_guard <= 1'b1;
        end else begin
            r_pre   <= r_pre + 1'b1;
            r_guard <= 1'b0;
        end
    end

    // Select the current nibble and decide leading-zero / guard blanking.
    always_comb begin
        w_digit      = '0;
        w_upper_zero = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (IDX_W'(d) == r_idx) begin
                w_digit = w_disp_next[4*d +: 4];
            end
            if ((d >= int'(r_idx)) && (w_disp_next[4*d +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_blank = r_guard | (i_lz_blank & (r_idx != '0) & w_upper_zero);
        w_sel   = r_guard ? SEL_OFF : ~(DIGITS'(1) << r_idx);
    end

    // Registered pin drivers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit_sel <= ~DIGITS'(1);
            r_bcd       <= 4'h0;
            r_blank     <= 1'b0;
        end else begin
            r_digit_sel <= w_sel;
            r_bcd       <= w_digit;
            r_blank     <= w_blank;
        end
    end

    assign o_busy      = w_conv_busy;
    assign o_digit_sel = r_digit_sel;
    assign o_bcd       = r_bcd;
    assign o_blank     = r_blank;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with DIV=4: a time-based reference model predicts every
// pin each cycle, and directed scenarios pin the model with literal expectations.
module tb_fnd_scan_ctrl;

    logic        clk;
    logic        i_reset;
    logic        i_load;
    logic [13:0] i_bin;
    logic        i_lz_blank;
    logic        o_busy;
    logic [3:0]  o_digit_sel;
    logic [3:0]  o_bcd;
    logic        o_blank;

    int n_chk  = 0;
    int n_pass = 0;

    fnd_scan_ctrl #(
        .CLK_HZ  (1000),
        .SCAN_HZ (250),
        .DIGITS  (4),
        .BIN_W   (14)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_load      (i_load),
        .i_bin       (i_bin),
        .i_lz_blank  (i_lz_blank),
        .o_busy      (o_busy),
        .o_digit_sel (o_digit_sel),
        .o_bcd       (o_bcd),
        .o_blank     (o_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endfunction

    // ---------------- reference model ----------------
    // Pins in cycle c+1 follow from cycle c: scan position is pure arithmetic on
    // the cycle count since reset; the display value is an integer.
    int         m_cyc;
    int         m_disp;
    int         m_pend;
    int         m_left;
    bit         m_valid = 0;
    logic [3:0] e_sel;
    logic [3:0] e_bcd;
    logic       e_blank;
    logic       e_busy;
    bit         e_guard;
    int         p10[4] = '{1, 10, 100, 1000};

    always @(posedge clk) begin
        int idx;
        int v;
        int digs[4];
        bit gd;
        if (i_reset) begin
            m_cyc   = 0;
            m_disp  = 0;
            m_left  = 0;
            e_sel   = 4'b1110;
            e_bcd   = 4'h0;
            e_blank = 1'b0;
            e_busy  = 1'b0;
            e_guard = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            gd  = (m_cyc > 0) && (m_cyc % 4 == 0);
            idx = (m_cyc / 4) % 4;
            if (m_left == 1) m_disp = m_pend;
            if (m_left > 0) m_left--;
            else if (i_load) begin
                m_pend = (int'(i_bin) > 9999) ? 9999 : int'(i_bin);
                m_left = 14;
            end
            v = m_disp;
            for (int d = 0; d < 4; d++) begin
                digs[d] = v % 10;
                v = v / 10;
            end
            e_sel   = gd ? 4'hF : ~(4'b0001 << idx);
            e_bcd   = 4'(digs[idx]);
            e_blank = gd || (i_lz_blank && idx >= 1 && m_disp < p10[idx]);
            e_busy  = (m_left > 0);
            e_guard = gd;
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_busy", 32'(o_busy), 32'(e_busy));
            chk("model_sel", 32'(o_digit_sel), 32'(e_sel));
            chk("model_blank", 32'(o_blank), 32'(e_blank));
            if (!e_guard) chk("model_bcd", 32'(o_bcd), 32'(e_bcd));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] cap_bcd[4];
    logic       cap_blank[4];
    int         cap_guards;
    int         cap_order_err;

    task automatic do_load(input int v, input int extra, output int busy_cyc);
        @(negedge clk);
        i_bin  = 14'(v);
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        busy_cyc = 0;
        for (int k = 0; k < 40 && o_busy; k++) begin
            busy_cyc++;
            if (k == 3 && extra >= 0) begin
                i_bin  = 14'(extra);
                i_load = 1'b1;
            end else begin
                i_load = 1'b0;
            end
            @(negedge clk);
        end
        i_load = 1'b0;
    endtask

    task automatic scan_capture();
        int prev;
        prev = -1;
        cap_guards = 0;
        cap_order_err = 0;
        for (int d = 0; d < 4; d++) begin
            cap_bcd[d]   = 4'bxxxx;
            cap_blank[d] = 1'bx;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (o_digit_sel == 4'hF) begin
                cap_guards++;
                if (o_blank !== 1'b1) cap_order_err++;
            end else begin
                int d;
                d = -1;
                for (int j = 0; j < 4; j++) if (o_digit_sel == ~(4'b0001 << j)) d = j;
                if (d < 0) cap_order_err++;
                else begin
                    cap_bcd[d]   = o_bcd;
                    cap_blank[d] = o_blank;
                    if (prev >= 0 && d != prev && d != (prev + 1) % 4) cap_order_err++;
                    prev = d;
                end
            end
        end
    endtask

    initial begin
        int bc;
        i_reset    = 1'b1;
        i_load     = 1'b0;
        i_bin      = '0;
        i_lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(o_digit_sel), 32'h0000000E);
        chk("rst_bcd", 32'(o_bcd), 32'h0);
        chk("rst_blank", 32'(o_blank), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        i_reset = 1'b0;
        repeat (3) @(negedge clk);

        // 1234, no leading-zero blanking
        do_load(1234, -1, bc);
        chk("busy_len_1234", 32'(bc), 32'd14);
        scan_capture();
        chk("d0_1234", 32'(cap_bcd[0]), 32'd4);
        chk("d1_1234", 32'(cap_bcd[1]), 32'd3);
        chk("d2_1234", 32'(cap_bcd[2]), 32'd2);
        chk("d3_1234", 32'(cap_bcd[3]), 32'd1);
        chk("b3_1234", 32'(cap_blank[3]), 32'd0);
        chk("guards_1234", 32'(cap_guards), 32'd8);
        chk("order_1234", 32'(cap_order_err), 32'd0);

        // 7 with leading-zero blanking
        i_lz_blank = 1'b1;
        do_load(7, -1, bc);
        scan_capture();
        chk("d0_7", 32'(cap_bcd[0]), 32'd7);
        chk("b0_7", 32'(cap_blank[0]), 32'd0);
        chk("b1_7", 32'(cap_blank[1]), 32'd1);
        chk("b2_7", 32'(cap_blank[2]), 32'd1);
        chk("b3_7", 32'(cap_blank[3]), 32'd1);

        // 0 shows a single "0"
        do_load(0, -1, bc);
        scan_capture();
        chk("d0_0", 32'(cap_bcd[0]), 32'd0);
        chk("b0_0", 32'(cap_blank[0]), 32'd0);
        chk("b1_0", 32'(cap_blank[1]), 32'd1);
        chk("b3_0", 32'(cap_blank[3]), 32'd1);

        // 12000 saturates; a load during busy is ignored
        i_lz_blank = 1'b0;
        do_load(12000, 55, bc);
        chk("busy_len_sat", 32'(bc), 32'd14);
        scan_capture();
        chk("d0_sat", 32'(cap_bcd[0]), 32'd9);
        chk("d1_sat", 32'(cap_bcd[1]), 32'd9);
        chk("d2_sat", 32'(cap_bcd[2]), 32'd9);
        chk("d3_sat", 32'(cap_bcd[3]), 32'd9);

        // Reset in the fifth busy cycle aborts the conversion
        @(negedge clk);
        i_bin  = 14'd4321;
        i_load = 1'b1;
        @(negedge clk);
        i_load = 1'b0;
        chk("abort_busy_started", 32'(o_busy), 32'd1);
        repeat (4) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_sel", 32'(o_digit_sel), 32'h0000000E);
        scan_capture();
        chk("abort_d0", 32'(cap_bcd[0]), 32'd0);
        chk("abort_d1", 32'(cap_bcd[1]), 32'd0);
        chk("abort_d3", 32'(cap_bcd[3]), 32'd0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
